// File: rtl/cc_mux_scan_pkg.sv
// rtl/cc_mux_scan_pkg.sv - shared state and mode encodings for the scanning word mux
package cc_mux_scan_pkg;

  typedef enum logic [1:0] {
    MUXSCAN_STATE_MANUAL = 2'b00,
    MUXSCAN_STATE_SCAN   = 2'b01,
    MUXSCAN_STATE_EMPTY  = 2'b10
  } muxScanState_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/cc_mux_scan_next.sv
// rtl/cc_mux_scan_next.sv - combinational round-robin finder: next set mask bit after currentIndex
module cc_mux_scan_next #(
  parameter int CHANNELS    = 10,
  parameter int SELECTWIDTH = 4
) (
  input  logic [CHANNELS-1:0]    enableMask,
  input  logic [SELECTWIDTH-1:0] currentIndex,
  output logic [SELECTWIDTH-1:0] nextIndex,
  output logic                   found
);

  logic [SELECTWIDTH-1:0] startSel;
  logic [CHANNELS-1:0]    rotated;
  int                     idx;

  always_comb begin
    nextIndex = '0;
    found     = 1'b0;
    idx       = 0;
    // An index at or past the last channel wraps the search back to channel 0.
    startSel  = (int'(currentIndex) >= CHANNELS - 1) ? '0 : currentIndex + SELECTWIDTH'(1);
    rotated   = CHANNELS'({enableMask, enableMask} >> startSel);
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        idx = int'(startSel) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        nextIndex = SELECTWIDTH'(idx);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cc_mux_scan.sv
// rtl/cc_mux_scan.sv - N-channel registered word mux with manual select and dwell-timed auto-scan
module cc_mux_scan
  import cc_mux_scan_pkg::*;
#(
  parameter int MUXSCAN_CHANNELS    = 10,
  parameter int MUXSCAN_DATAWIDTH   = 8,
  parameter int MUXSCAN_SELECTWIDTH = 4,
  parameter int MUXSCAN_DWELLWIDTH  = 16
) (
  input  logic                                        CC_MUXSCAN_CLOCK_50,
  input  logic                                        CC_MUXSCAN_RESET_InLow,
  input  logic                                        CC_MUXSCAN_mode_In,
  input  logic [MUXSCAN_SELECTWIDTH-1:0]              CC_MUXSCAN_select_InBUS,
  input  logic [MUXSCAN_CHANNELS-1:0]                 CC_MUXSCAN_enable_InBUS,
  input  logic [MUXSCAN_DWELLWIDTH-1:0]               CC_MUXSCAN_dwell_InBUS,
  input  logic [MUXSCAN_CHANNELS*MUXSCAN_DATAWIDTH-1:0] CC_MUXSCAN_data_InBUS,
  output logic [MUXSCAN_DATAWIDTH-1:0]                CC_MUXSCAN_z_OutBUS,
  output logic [MUXSCAN_SELECTWIDTH-1:0]              CC_MUXSCAN_channel_OutBUS,
  output logic                                        CC_MUXSCAN_valid_Out,
  output logic                                        CC_MUXSCAN_advance_Out
);

  muxScanState_e                  state, nextState;
  logic [MUXSCAN_DWELLWIDTH-1:0]  dwellCount, curCount;
  logic [MUXSCAN_SELECTWIDTH-1:0] nextIdx;
  logic                           nextFound, selLegal, curEnabled, expire;

  function automatic logic [MUXSCAN_DATAWIDTH-1:0] pickWord(
    input logic [MUXSCAN_CHANNELS*MUXSCAN_DATAWIDTH-1:0] bus,
    input logic [MUXSCAN_SELECTWIDTH-1:0]                idx
  );
    return MUXSCAN_DATAWIDTH'(bus >> (int'(idx) * MUXSCAN_DATAWIDTH));
  endfunction

  cc_mux_scan_next #(
    .CHANNELS   (MUXSCAN_CHANNELS),
    .SELECTWIDTH(MUXSCAN_SELECTWIDTH)
  ) u_next (
    .enableMask  (CC_MUXSCAN_enable_InBUS),
    .currentIndex(CC_MUXSCAN_channel_OutBUS),
    .nextIndex   (nextIdx),
    .found       (nextFound)
  );

  // The action on each edge follows the live mode/mask, so mode changes take effect immediately.
  always_comb begin
    nextState = MUXSCAN_STATE_MANUAL;
    if (CC_MUXSCAN_mode_In == MODE_SCAN)
      nextState = (|CC_MUXSCAN_enable_InBUS) ? MUXSCAN_STATE_SCAN : MUXSCAN_STATE_EMPTY;
  end

  always_comb begin
    selLegal   = (int'(CC_MUXSCAN_select_InBUS) < MUXSCAN_CHANNELS) &&
                 (|(CC_MUXSCAN_enable_InBUS & (MUXSCAN_CHANNELS'(1) << CC_MUXSCAN_select_InBUS)));
    curEnabled = (int'(CC_MUXSCAN_channel_OutBUS) < MUXSCAN_CHANNELS) &&
                 (|(CC_MUXSCAN_enable_InBUS & (MUXSCAN_CHANNELS'(1) << CC_MUXSCAN_channel_OutBUS)));
    // Entering scan from any other state always starts a fresh dwell.
    curCount   = (state == MUXSCAN_STATE_SCAN) ? dwellCount : '0;
    expire     = !curEnabled || (curCount >= CC_MUXSCAN_dwell_InBUS);
  end

  always_ff @(posedge CC_MUXSCAN_CLOCK_50 or negedge CC_MUXSCAN_RESET_InLow) begin
    if (!CC_MUXSCAN_RESET_InLow) state <= MUXSCAN_STATE_MANUAL;
    else                         state <= nextState;
  end

  always_ff @(posedge CC_MUXSCAN_CLOCK_50 or negedge CC_MUXSCAN_RESET_InLow) begin
    if (!CC_MUXSCAN_RESET_InLow) begin
      CC_MUXSCAN_z_OutBUS       <= '0;
      CC_MUXSCAN_channel_OutBUS <= '0;
      CC_MUXSCAN_valid_Out      <= 1'b0;
      CC_MUXSCAN_advance_Out    <= 1'b0;
      dwellCount                <= '0;
    end else begin
      case (nextState)
        MUXSCAN_STATE_SCAN: begin
          CC_MUXSCAN_valid_Out <= 1'b1;
          if (expire && nextFound) begin
            dwellCount                <= '0;
            CC_MUXSCAN_channel_OutBUS <= nextIdx;
            CC_MUXSCAN_z_OutBUS       <= pickWord(CC_MUXSCAN_data_InBUS, nextIdx);
            CC_MUXSCAN_advance_Out    <= 1'b1;
          end else begin
            dwellCount             <= curCount + MUXSCAN_DWELLWIDTH'(1);
            CC_MUXSCAN_z_OutBUS    <= pickWord(CC_MUXSCAN_data_InBUS, CC_MUXSCAN_channel_OutBUS);
            CC_MUXSCAN_advance_Out <= 1'b0;
          end
        end
        MUXSCAN_STATE_EMPTY: begin
          CC_MUXSCAN_valid_Out   <= 1'b0;
          CC_MUXSCAN_advance_Out <= 1'b0;
          dwellCount             <= '0;
        end
        default: begin
          if (selLegal) begin
            CC_MUXSCAN_z_OutBUS       <= pickWord(CC_MUXSCAN_data_InBUS, CC_MUXSCAN_select_InBUS);
            CC_MUXSCAN_channel_OutBUS <= CC_MUXSCAN_select_InBUS;
          end
          CC_MUXSCAN_valid_Out   <= selLegal;
          CC_MUXSCAN_advance_Out <= 1'b0;
          dwellCount             <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_mux_scan.sv
// tb/tb_cc_mux_scan.sv - scoreboard bench for cc_mux_scan against a behavioural channel-scan model
module tb_cc_mux_scan;

  localparam int CH = 10;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int WW = 16;

  typedef struct packed {
    logic [DW-1:0] z;
    logic [SW-1:0] ch;
    logic          v;
    logic          adv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          mode;
  logic [SW-1:0] sel;
  logic [CH-1:0] en;
  logic [WW-1:0] dwell;
  logic [DW-1:0] dataArr [CH];
  logic [CH*DW-1:0] dataBus;
  logic [DW-1:0] z;
  logic [SW-1:0] chOut;
  logic          valid, advance;

  exp_t expQ [$];
  exp_t eMon;
  int   checks = 0;
  int   fails  = 0;

  logic [DW-1:0] mZ;
  int            mCh, mCnt;
  logic          mV, mAdv;
  logic          reached;

  always #5 clk = ~clk;

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign dataBus[g*DW +: DW] = dataArr[g];
  end

  cc_mux_scan dut (
    .CC_MUXSCAN_CLOCK_50      (clk),
    .CC_MUXSCAN_RESET_InLow   (rstN),
    .CC_MUXSCAN_mode_In       (mode),
    .CC_MUXSCAN_select_InBUS  (sel),
    .CC_MUXSCAN_enable_InBUS  (en),
    .CC_MUXSCAN_dwell_InBUS   (dwell),
    .CC_MUXSCAN_data_InBUS    (dataBus),
    .CC_MUXSCAN_z_OutBUS      (z),
    .CC_MUXSCAN_channel_OutBUS(chOut),
    .CC_MUXSCAN_valid_Out     (valid),
    .CC_MUXSCAN_advance_Out   (advance)
  );

  function automatic int nextEnabled(input int cur, input logic [CH-1:0] m);
    for (int off = 1; off <= CH; off++) begin
      if (m[(cur + off) % CH]) return (cur + off) % CH;
    end
    return cur;
  endfunction

  // One clock edge of the block, described from the behavioural rules.
  task automatic modelEdge();
    if (!rstN) begin
      mZ = '0; mCh = 0; mV = 1'b0; mAdv = 1'b0; mCnt = 0;
    end else if (!mode) begin
      if (int'(sel) < CH && en[sel]) begin
        mZ = dataArr[sel]; mCh = int'(sel); mV = 1'b1;
      end else begin
        mV = 1'b0;
      end
      mAdv = 1'b0; mCnt = 0;
    end else if (en == '0) begin
      mV = 1'b0; mAdv = 1'b0; mCnt = 0;
    end else begin
      if (!en[mCh] || mCnt >= int'(dwell)) begin
        mCh = nextEnabled(mCh, en); mCnt = 0; mAdv = 1'b1;
      end else begin
        mCnt = mCnt + 1; mAdv = 1'b0;
      end
      mZ = dataArr[mCh]; mV = 1'b1;
    end
  endtask

  task automatic step();
    exp_t e;
    modelEdge();
    e = '{z: mZ, ch: SW'(mCh), v: mV, adv: mAdv};
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic randomData();
    for (int k = 0; k < CH; k++) dataArr[k] = DW'($urandom);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        eMon = expQ.pop_front();
        checks++;
        if ({z, chOut, valid, advance} !== eMon) begin
          fails++;
          $display("FAIL out @%0t: got z=%h ch=%0d valid=%b adv=%b, required z=%h ch=%0d valid=%b adv=%b",
                   $time, z, chOut, valid, advance, eMon.z, eMon.ch, eMon.v, eMon.adv);
        end
      end
    end
  end

  initial begin
    rstN = 1'b0; mode = 1'b0; sel = '0; en = '1; dwell = '0;
    randomData();
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      mode = 1'($urandom); sel = SW'($urandom); en = CH'($urandom); dwell = WW'($urandom);
      randomData();
      step();
    end

    rstN = 1'b1; mode = 1'b0; sel = 4'd3; en = '1; dwell = '0;
    dataArr[3] = 8'hA5;
    step();

    dataArr[5] = 8'h3C; sel = 4'd5; step();
    sel = 4'd12; step(); step();
    en = 10'b11_1111_1011; sel = 4'd2; step();

    en = '1; sel = 4'd0; step();
    mode = 1'b1; en = 10'b10_0000_1001; dwell = 16'd2;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) dataArr[3] = 8'h11;
      if (i == 4) dataArr[3] = 8'h22;
      step();
    end

    dwell = 16'd0; en = 10'b00_0000_0011;
    for (int i = 0; i < 6; i++) step();

    en = '0;
    for (int i = 0; i < 3; i++) step();
    en = 10'b00_0001_0000;
    for (int i = 0; i < 3; i++) step();

    en = 10'b10_0000_0000; dwell = 16'd9;
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mCh == 9 && mCnt == 5) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!reached) begin
      fails++;
      $display("FAIL reach_ch9_cnt5: got ch=%0d cnt=%0d, required ch=9 cnt=5", mCh, mCnt);
    end

    rstN = 1'b0;
    #1;
    checks++;
    if ({z, chOut, valid, advance} !== '0) begin
      fails++;
      $display("FAIL async_reset: got z=%h ch=%0d valid=%b adv=%b, required all zero",
               z, chOut, valid, advance);
    end
    step(); step();
    rstN = 1'b1; mode = 1'b1; en = '1; dwell = 16'd1;
    for (int i = 0; i < 5; i++) step();

    for (int i = 0; i < 400; i++) begin
      mode  = ($urandom_range(0, 3) != 0);
      sel   = SW'($urandom_range(0, 15));
      en    = ($urandom_range(0, 7) == 0) ? '0 : CH'($urandom);
      dwell = WW'($urandom_range(0, 3));
      for (int k = 0; k < CH; k++)
        if ($urandom_range(0, 3) == 0) dataArr[k] = DW'($urandom);
      step();
    end

    repeat (2) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, required 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
